// File: rtl/step_motor_ctrl.sv
// step_motor_ctrl: commanded, abortable stepper-motor phase sequencer.
// Accepts a move (steps, dir, period), walks the coil pattern at the commanded
// rate and reports busy/done/remaining. Optional macro HALF_STEP_EN selects the
// 8-entry half-step table instead of the 4-entry full-step table.
module step_motor_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    output logic [3:0]       phase,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

`ifdef HALF_STEP_EN
    localparam int unsigned IDX_W = 3;
`else
    localparam int unsigned IDX_W = 2;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [3:0]       phase_n;
    logic             busy_n;
    logic             done_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic [DIV_W-1:0] presc_q, presc_n;
    logic [DIV_W-1:0] period_q, period_n;
    logic             dir_q, dir_n;
    logic             tick;

    // Coil pattern for a table index; wrap is implicit in the index width.
    function automatic logic [3:0] pattern_of(input logic [IDX_W-1:0] i);
        logic [3:0] p;
        p = 4'b0001;
`ifdef HALF_STEP_EN
        case (i)
            3'd0: p = 4'b0001;
            3'd1: p = 4'b0011;
            3'd2: p = 4'b0010;
            3'd3: p = 4'b0110;
            3'd4: p = 4'b0100;
            3'd5: p = 4'b1100;
            3'd6: p = 4'b1000;
            3'd7: p = 4'b1001;
            default: p = 4'b0001;
        endcase
`else
        case (i)
            2'd0: p = 4'b0001;
            2'd1: p = 4'b0010;
            2'd2: p = 4'b0100;
            2'd3: p = 4'b1000;
            default: p = 4'b0001;
        endcase
`endif
        return p;
    endfunction

    // Step tick when the prescaler reaches the latched period minus one.
    assign tick = (presc_q == (period_q - DIV_W'(1)));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            phase     <= 4'b0001;
            busy      <= 1'b0;
            done      <= 1'b0;
            rem_q     <= '0;
            presc_q   <= '0;
            period_q  <= DIV_W'(1);
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            phase     <= phase_n;
            busy      <= busy_n;
            done      <= done_n;
            rem_q     <= rem_n;
            presc_q   <= presc_n;
            period_q  <= period_n;
            dir_q     <= dir_n;
        end
    end

    assign remaining = rem_q;

    // Next-state and next-output logic; stop always wins over start and tick.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        busy_n   = busy;
        done_n   = 1'b0;
        rem_n    = rem_q;
        presc_n  = presc_q;
        period_n = period_q;
        dir_n    = dir_q;

        case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                if (start && !stop) begin
                    if (steps != '0) begin
                        state_n  = RUN;
                        busy_n   = 1'b1;
                        rem_n    = steps;
                        presc_n  = '0;
                        dir_n    = dir;
                        period_n = (period == '0) ? DIV_W'(1) : period;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (tick) begin
                    presc_n = '0;
                    idx_n   = dir_q ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
                    rem_n   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    presc_n = presc_q + DIV_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        phase_n = pattern_of(idx_n);
    end

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Self-checking bench for step_motor_ctrl: directed moves from the test plan
// plus randomized moves, checked against a move-level timing model.
module tb_step_motor_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIV_W = 16;
`ifdef HALF_STEP_EN
    localparam int L = 8;
`else
    localparam int L = 4;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic [3:0]       phase;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int total;
    int bad;
    int m_idx;
    int m_rem;
    logic [3:0] tbl [8];

    step_motor_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .steps     (steps),
        .period    (period),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap(input int x);
        return ((x % L) + L) % L;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int e_idx, input bit e_busy,
                           input bit e_done, input int e_rem);
        chk({tag, ".phase"}, 32'(phase), 32'(tbl[e_idx]));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        chk({tag, ".remaining"}, 32'(remaining), 32'(e_rem));
    endtask

    // One command: n steps, direction d, period p; s>0 asserts stop so it is
    // sampled at edge E0+s (1 <= s <= n*P). Random junk is driven on start
    // while the move is running to show it is ignored.
    task automatic run_move(input string tag, input int n, input bit d, input int p, input int s);
        int pe;
        int fin;
        int taken;
        bit stopped;
        pe      = (p == 0) ? 1 : p;
        stopped = (s != 0);
        fin     = (n == 0) ? 0 : (stopped ? s : n * pe);
        @(negedge clk);
        start  = 1'b1;
        stop   = 1'b0;
        dir    = d;
        steps  = CNT_W'(n);
        period = DIV_W'(p);
        @(posedge clk);
        taken = 0;
        for (int t = 0; t <= fin + 1; t++) begin
            @(negedge clk);
            if (n == 0)        taken = 0;
            else if (t < fin)  taken = t / pe;
            else               taken = stopped ? (s - 1) / pe : n;
            chk_all(tag, wrap(m_idx + (d ? taken : -taken)),
                    (n != 0) && (t < fin), (t == fin) && !stopped,
                    (n == 0) ? m_rem : n - taken);
            start  = (t < fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            dir    = 1'($urandom);
            steps  = CNT_W'($urandom);
            period = DIV_W'($urandom_range(0, 3));
            stop   = stopped && (t == s - 1);
        end
        stop  = 1'b0;
        m_idx = wrap(m_idx + (d ? taken : -taken));
        if (n != 0) m_rem = n - taken;
    endtask

    initial begin
        int n;
        int p;
        int s;
        bit d;
`ifdef HALF_STEP_EN
        tbl[0] = 4'b0001; tbl[1] = 4'b0011; tbl[2] = 4'b0010; tbl[3] = 4'b0110;
        tbl[4] = 4'b0100; tbl[5] = 4'b1100; tbl[6] = 4'b1000; tbl[7] = 4'b1001;
`else
        tbl[0] = 4'b0001; tbl[1] = 4'b0010; tbl[2] = 4'b0100; tbl[3] = 4'b1000;
        tbl[4] = 4'b0001; tbl[5] = 4'b0010; tbl[6] = 4'b0100; tbl[7] = 4'b1000;
`endif
        total  = 0;
        bad    = 0;
        m_idx  = 0;
        m_rem  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        dir    = 1'b0;
        steps  = '0;
        period = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 1'b0, 1'b0, 0);
        rst = 1'b1;

        // Directed moves from the plan.
        run_move("fwd4_p3", 4, 1'b1, 3, 0);
        run_move("rev2_p0", 2, 1'b0, 0, 0);
        run_move("stop10_p2", 10, 1'b1, 2, 6);
        chk("stop10_p2.rem8", 32'(remaining), 32'd8);
        run_move("one_step", 1, 1'b1, 1, 0);
        run_move("zero_steps", 0, 1'b1, 2, 0);

        // Start and stop together in IDLE: no response.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        steps = CNT_W'(5);
        dir   = 1'b1;
        period = DIV_W'(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all("start_stop_idle", m_idx, 1'b0, 1'b0, m_rem);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset in the middle of a 5-step move after 2 steps.
        @(negedge clk);
        start  = 1'b1;
        steps  = CNT_W'(5);
        dir    = 1'b1;
        period = DIV_W'(2);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_all("pre_reset", wrap(m_idx + 2), 1'b1, 1'b0, 3);
        #2 rst = 1'b0;
        #1;
        chk_all("mid_reset", 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst   = 1'b1;
        m_idx = 0;
        m_rem = 0;

        // Nine forward single-cycle steps from index 0 (half-step walk test).
        run_move("walk9_p1", 9, 1'b1, 1, 0);

        // Randomized moves with occasional aborts.
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, 12);
            if (n == 0 && m_rem != 0) n = 1;
            p = $urandom_range(0, 4);
            d = 1'($urandom);
            s = 0;
            if (n != 0 && $urandom_range(0, 2) == 0)
                s = $urandom_range(1, n * ((p == 0) ? 1 : p));
            run_move("rand", n, d, p, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_motor_ctrl.md
# step_motor_ctrl

Sequencer for the 4-coil stepper motor phase outputs in the motor datapath. It accepts a move command (step count, direction, step period), generates the coil phase pattern at the commanded rate, and reports busy/done. It replaces the free-running divider-chain stepping with a commanded, abortable move, using the same system clock domain.

## Interface
- CNT_W, 8, width of step-count command and remaining counter
- DIV_W, 16, width of step-period prescaler

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level-sampled move request, honoured only in IDLE
- stop  in  1  abort request, honoured only in RUN
- dir  in  1  1 = forward (index +1), 0 = reverse (index −1); latched at start
- steps  in  CNT_W  number of steps to move; latched at start
- period  in  DIV_W  clk cycles per step; latched at start; 0 is treated as 1
- phase  out  4  coil drive pattern, registered
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on normal move completion
- remaining  out  CNT_W  steps not yet taken

## Operation
- States: IDLE, RUN.
- Reset (rst low, asynchronous): state IDLE, phase index 0 (phase = 4'b0001), busy 0, done 0, remaining 0, prescaler 0.
- Full-step table, index 0..3: 0001, 0010, 0100, 1000. Index wraps modulo table length in both directions.
- IDLE: phase holds last pattern (holding torque). done is 0 except for its completion pulse.
- IDLE, start=1, stop=0, steps≠0: latch dir/steps/period, remaining ← steps, prescaler ← 0, busy ← 1, go RUN.
- IDLE, start=1, stop=0, steps=0: stay IDLE, no phase change, done pulses for 1 cycle.
- IDLE, start=1 and stop=1 in the same cycle: stop wins; nothing happens.
- RUN: prescaler increments each clk. When prescaler = P−1 (P = latched period, min 1), prescaler ← 0, index ± 1, remaining − 1.
- The step that makes remaining 0 also sets busy ← 0, done ← 1 for one cycle, and state ← IDLE (same edge).
- RUN, stop=1: at the next edge go IDLE; busy ← 0; phase and remaining freeze at current values; done stays 0. stop and a step tick on the same edge: stop wins, step not taken.
- start during RUN is ignored; new inputs have no effect until IDLE.
- remaining never underflows; index arithmetic is modulo table length.

## Timing
- Edge E0 samples start in IDLE. After E0: busy=1, remaining=N, prescaler=0.
- Step k (1..N) updates phase at edge E0+k·P. The first step comes P cycles after acceptance.
- Completion: after edge E0+N·P, phase=final pattern, remaining=0, busy=0, done=1. done=0 after the next edge.
- A new start can be accepted on the edge after completion, i.e. the cycle done is high.
- Zero-step command: done=1 during the cycle after E0.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- HALF_STEP_EN defined: 8-entry half-step table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Each step advances one half-step. Wrap is modulo 8.
- HALF_STEP_EN undefined: 4-entry full-step table as above. Wrap is modulo 4.
- In both modes the reset pattern is 0001.

## Test plan
- Reset, then start with steps=4, dir=1, period=3 → phase 0010/0100/1000/0001 at E0+3/+6/+9/+12. Single done pulse after E0+12. busy high E0..E0+12.
- Start with steps=2, dir=0, period=0 from index 0 → phase 1000 at E0+1, 0100 at E0+2. done after E0+2 (period 0 behaves as 1).
- Start with steps=10, period=2, stop at E0+5 → busy=0 after E0+6. remaining=8 (steps at E0+2, E0+4). phase frozen. No done.
- Start with steps=0 → done pulse 1 cycle, busy never high, phase unchanged. Start+stop together in IDLE → no response.
- Assert rst low mid-move (steps=5, after 2 steps) → immediately phase=0001, busy=0, remaining=0, done=0. Later start runs normally.
- HALF_STEP_EN: steps=9, dir=1, period=1 → phase walks 0011,0010,0110,0100,1100,1000,1001,0001,0011 on successive edges.
